// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: error status encoding, FIFO entry, pointer sizing.
package uart_pkg;

  // Error status as produced by uart_rx.
  typedef logic [1:0] uart_err_t;
  localparam int unsigned UartErrFrameBit  = 0;  // stop bit sampled low
  localparam int unsigned UartErrParityBit = 1;  // parity mismatch

  localparam int unsigned UartDataWidth = 8;

  typedef struct packed {
    uart_err_t                  err;
    logic [UartDataWidth-1:0]   data;
  } uart_rx_entry_t;

  // A depth of one still needs a one-bit pointer to keep the vector legal.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Receive-timeout counter: counts baud_x16 ticks while data sits unread, saturating at the limit.
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_tick,
  input  logic i_active,
  input  logic i_clear,
  output logic o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_TICKS) + 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_TICKS);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_active) begin
      cnt_d = '0;
    end else if (i_tick && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_timeout = (cnt_q == Limit);

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive FIFO behind uart_rx with sticky overrun flag.
// Define UART_RX_TIMEOUT_EN to build the receive-timeout counter; otherwise o_timeout is 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [DATA_WIDTH-1:0]    i_din,
  input  logic                     i_valid,
  input  logic [1:0]               i_error,
  input  logic                     i_baud_x16,
  input  logic                     i_rd_en,
  input  logic                     i_clr_overrun,
  output logic [DATA_WIDTH-1:0]    o_dout,
  output logic [1:0]               o_derr,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overrun,
  output logic                     o_timeout
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef struct packed {
    uart_err_t               err;
    logic [DATA_WIDTH-1:0]   data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            do_push, do_pop, drop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CntW'(DEPTH));

  // A pop frees the slot the same cycle, so a write into a full FIFO with a pop is accepted.
  assign do_pop  = i_rd_en && !o_empty;
  assign do_push = i_valid && (!o_full || do_pop);
  assign drop    = i_valid && o_full && !do_pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (i_clr_overrun) overrun_d = 1'b0;
    if (drop)          overrun_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; the outputs are masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= '{err: i_error, data: i_din};
    end
  end

  assign o_dout    = o_empty ? '0 : mem_q[rd_ptr_q].data;
  assign o_derr    = o_empty ? '0 : mem_q[rd_ptr_q].err;
  assign o_count   = count_q;
  assign o_overrun = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
  uart_rx_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_tick    (i_baud_x16),
    .i_active  (!o_empty),
    .i_clear   (do_push || do_pop),
    .o_timeout (o_timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = i_baud_x16 ^ (TIMEOUT_TICKS == 0);
  assign o_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo using a queue scoreboard of {err, data} entries.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TICKS = 640;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] din;
  logic          valid;
  logic [1:0]    err;
  logic          baud;
  logic          rd_en;
  logic          clr_ovr;
  logic [DW-1:0] dout;
  logic [1:0]    derr;
  logic          empty;
  logic          full;
  logic [4:0]    count;
  logic          overrun;
  logic          timeout;

  int checks   = 0;
  int failures = 0;
  logic [9:0] sb [$];

  uart_rx_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .TIMEOUT_TICKS (TICKS)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_din         (din),
    .i_valid       (valid),
    .i_error       (err),
    .i_baud_x16    (baud),
    .i_rd_en       (rd_en),
    .i_clr_overrun (clr_ovr),
    .o_dout        (dout),
    .o_derr        (derr),
    .o_empty       (empty),
    .o_full        (full),
    .o_count       (count),
    .o_overrun     (overrun),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d, input logic [1:0] e, input bit expect_ok);
    valid = 1'b1; din = d; err = e;
    if (expect_ok) sb.push_back({e, d});
    cycle();
    valid = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [9:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, dut dout=%h empty=%b", name, dout, empty);
    end else begin
      exp = sb.pop_front();
      if (empty !== 1'b0 || {derr, dout} !== exp) begin
        failures++;
        $display("FAIL %s: got empty=%b derr=%b dout=%h, need empty=0 derr=%b dout=%h",
                 name, empty, derr, dout, exp[9:8], exp[7:0]);
      end
    end
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic check_state(input string name, input logic e, input logic f,
                             input logic [4:0] c, input logic o);
    checks++;
    if (empty !== e || full !== f || count !== c || overrun !== o) begin
      failures++;
      $display("FAIL %s: got empty=%b full=%b count=%0d overrun=%b, need %b %b %0d %b",
               name, empty, full, count, overrun, e, f, c, o);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    check_state("reset_flags", 1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (dout !== 8'h00 || derr !== 2'b00 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: got dout=%h derr=%b timeout=%b, need 00 00 0", dout, derr, timeout);
    end
    @(negedge clk);
    rstn = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    write(8'hA6, 2'b00, 1'b1);
    check_state("single_after_write", 1'b0, 1'b0, 5'd1, 1'b0);
    pop_check("single_pop");
    check_state("single_after_pop", 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) write(8'(i), 2'b00, 1'b1);
    check_state("fill_full", 1'b0, 1'b1, 5'd16, 1'b0);
    write(8'hFF, 2'b00, 1'b0);
    check_state("overrun_set", 1'b0, 1'b1, 5'd16, 1'b1);
    // Clear and a fresh drop in the same cycle: the drop wins.
    clr_ovr = 1'b1;
    write(8'hEE, 2'b00, 1'b0);
    clr_ovr = 1'b0;
    check_state("overrun_set_wins", 1'b0, 1'b1, 5'd16, 1'b1);
    for (int i = 0; i < 16; i++) pop_check("fill_drain");
    check_state("fill_drained", 1'b1, 1'b0, 5'd0, 1'b1);
    clr_ovr = 1'b1;
    cycle();
    clr_ovr = 1'b0;
    check_state("overrun_clear", 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) write(8'hA0 + 8'(i), 2'b10, 1'b1);
    // Pop head and write 0x55 in the same edge.
    valid = 1'b1; din = 8'h55; err = 2'b00;
    sb.push_back({2'b00, 8'h55});
    pop_check("b2b_head");
    valid = 1'b0;
    check_state("b2b_full_kept", 1'b0, 1'b1, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) pop_check("b2b_drain");
    check_state("b2b_drained", 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_empty_read();
    rd_en = 1'b1;
    repeat (3) cycle();
    rd_en = 1'b0;
    check_state("empty_rd_ignored", 1'b1, 1'b0, 5'd0, 1'b0);
    write(8'h3C, 2'b01, 1'b1);
    pop_check("derr_01");
    // Write plus pop on an empty FIFO: only the write takes effect.
    rd_en = 1'b1;
    write(8'hC3, 2'b11, 1'b1);
    rd_en = 1'b0;
    check_state("empty_wr_rd", 1'b0, 1'b0, 5'd1, 1'b0);
    pop_check("empty_wr_rd_data");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) write(8'h10 + 8'(i), 2'b00, 1'b1);
    check_state("burst_count7", 1'b0, 1'b0, 5'd7, 1'b0);
    valid = 1'b1; din = 8'h77;
    #3;
    rstn = 1'b0;
    #1;
    check_state("async_reset", 1'b1, 1'b0, 5'd0, 1'b0);
    valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    write(8'h9A, 2'b00, 1'b1);
    pop_check("post_reset_data");
  endtask

  task automatic test_timeout();
    write(8'h42, 2'b00, 1'b1);
    baud = 1'b1;
`ifdef UART_RX_TIMEOUT_EN
    repeat (TICKS - 1) cycle();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got %b need 0", timeout);
    end
    cycle();
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_at_limit: got %b need 1", timeout);
    end
`else
    repeat (TICKS + 20) cycle();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_disabled: got %b need 0", timeout);
    end
`endif
    baud = 1'b0;
    pop_check("timeout_data");
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_cleared: got %b need 0", timeout);
    end
  endtask

  initial begin
    rstn = 1'b0; din = '0; valid = 1'b0; err = '0;
    baud = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    test_reset();
    test_single();
    test_fill_overrun();
    test_back_to_back();
    test_empty_read();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
